// File: rtl/aes_key_sched_word.sv
// Word-serial AES key schedule: expands a 128/192/256-bit key into w[0..59]
// one word per EXPAND cycle and serves READ_PORTS combinational round-key ports.
module aes_key_sched_word #(
  parameter int unsigned SBOX_LANES = 4,
  parameter int unsigned READ_PORTS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [255:0]              key,
  input  logic [1:0]                keylen,
  input  logic                      init,
  input  logic [4*READ_PORTS-1:0]   rd_round,
  output logic [128*READ_PORTS-1:0] round_key,
  output logic                      ready,
  output logic                      busy,
  output logic                      keylen_err
);

  localparam int unsigned WORDS  = 60;
  localparam int unsigned IW     = 6;
  localparam bit          SERIAL = (SBOX_LANES == 1);

  // Forward AES S-box, row-major from input 8'h00 at the MSB end.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    SUB    = 2'd2
  } state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic needs_sub(input logic [2:0] pos, input logic [3:0] nk);
    return (pos == 3'd0) || ((nk == 4'd8) && (pos == 3'd4));
  endfunction

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   w [WORDS];
  logic [IW-1:0] idx;
  logic [2:0]    kpos;
  logic [7:0]    rcon;
  logic [1:0]    keylen_reg;
  logic [3:0]    nk_reg;
  logic [31:0]   hold;
  logic [1:0]    sub_cnt;

  logic          init_ok;
  logic          init_bad;
  logic [3:0]    nk_new;
  logic [3:0]    nr;
  logic [IW-1:0] t_last;
  logic          last;
  logic [2:0]    kpos_inc;
  logic          sub_cur;
  logic [31:0]   prev;
  logic [31:0]   old;
  logic [31:0]   sub_src;
  logic [31:0]   sub_out;
  logic [31:0]   temp;
  logic [31:0]   new_word;

  logic          load;
  logic          write_word;
  logic          sub_step;
  logic          finish;

  // Decode of the key length being offered and the one latched at init.
  always_comb begin
    init_ok  = init && (keylen != 2'b11);
    init_bad = init && (keylen == 2'b11);
    case (keylen)
      2'b00:   nk_new = 4'd4;
      2'b01:   nk_new = 4'd6;
      default: nk_new = 4'd8;
    endcase
    case (keylen_reg)
      2'b00:   begin nr = 4'd10; t_last = IW'(43); end
      2'b01:   begin nr = 4'd12; t_last = IW'(51); end
      default: begin nr = 4'd14; t_last = IW'(59); end
    endcase
    last     = (idx == t_last);
    kpos_inc = ({1'b0, kpos} == (nk_reg - 4'd1)) ? 3'd0 : kpos + 3'd1;
    sub_cur  = needs_sub(kpos, nk_reg);
  end

  // Next schedule word; the serial variant takes SubWord from the holding register.
  always_comb begin
    prev     = w[idx - IW'(1)];
    old      = w[idx - IW'(nk_reg)];
    sub_src  = (kpos == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub_out  = SERIAL ? hold : sub_word(sub_src);
    temp     = prev;
    if (sub_cur) begin
      temp = sub_out ^ ((kpos == 3'd0) ? {rcon, 24'h0} : 32'h0);
    end
    new_word = old ^ temp;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Serial mode looks one word ahead so SUB is entered without an idle EXPAND cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   state_nxt = IDLE;
      EXPAND: begin
        if (last) begin
          state_nxt = IDLE;
        end else if (SERIAL && needs_sub(kpos_inc, nk_reg)) begin
          state_nxt = SUB;
        end
      end
      SUB:    if (sub_cnt == 2'd3) state_nxt = EXPAND;
      default: state_nxt = IDLE;
    endcase
    if (init_ok) state_nxt = SERIAL ? SUB : EXPAND;
  end

  always_comb begin
    load       = init_ok;
    write_word = 1'b0;
    sub_step   = 1'b0;
    finish     = 1'b0;
    if (!init_ok) begin
      case (state)
        EXPAND: begin
          write_word = 1'b1;
          finish     = last;
        end
        SUB:     sub_step = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < WORDS; k++) w[k] <= 32'h0;
      idx        <= '0;
      kpos       <= 3'd0;
      rcon       <= 8'h01;
      keylen_reg <= 2'b00;
      nk_reg     <= 4'd4;
      hold       <= 32'h0;
      sub_cnt    <= 2'd0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      keylen_err <= 1'b0;
    end else begin
      keylen_err <= init_bad;
      if (load) begin
        for (int k = 0; k < 8; k++) begin
          if (4'(k) < nk_new) w[k] <= key[32*(7-k) +: 32];
        end
        idx        <= IW'(nk_new);
        kpos       <= 3'd0;
        rcon       <= 8'h01;
        keylen_reg <= keylen;
        nk_reg     <= nk_new;
        sub_cnt    <= 2'd0;
        ready      <= 1'b0;
        busy       <= 1'b1;
      end else begin
        if (write_word) begin
          w[idx] <= new_word;
          idx    <= idx + IW'(1);
          kpos   <= kpos_inc;
          if (kpos == 3'd0) rcon <= xtime(rcon);
          if (finish) begin
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        if (sub_step) begin
          hold    <= {hold[23:0], sbox(sub_src[{~sub_cnt, 3'b000} +: 8])};
          sub_cnt <= sub_cnt + 2'd1;
        end
      end
    end
  end

  // Rounds beyond the latched Nr read as zero.
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [3:0] r;
    assign r = rd_round[4*p +: 4];
    assign round_key[128*p +: 128] = (r <= nr) ?
      {w[{r, 2'b00}], w[{r, 2'b01}], w[{r, 2'b10}], w[{r, 2'b11}]} : 128'h0;
  end

endmodule
